// File: rtl/alu16_pkg.sv
// Shared definitions for the ALU execution controller.
// Holds the default datapath/address widths, the controller state type,
// and the ALU select codes.
package alu16_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_XNOR = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_ASHL = 4'b1010;
    localparam logic [3:0] OP_ASHR = 4'b1011;

endpackage

// File: rtl/alu16_exec_ctrl_if.sv
// Instruction / result handshake bundle for alu16_exec_ctrl.
// master: instruction source and result consumer.
// slave : the execution controller.
//   instr_valid/instr_ready  instruction handshake
//   instr_op/rd/rs1/rs2      instruction fields
//   res_valid                one-cycle write-back pulse
//   res_data/res_rd          last written result and its destination
//   zero_flag                Zero of the last completed instruction
interface alu16_exec_ctrl_if
    import alu16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        instr_op;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs1;
    logic [ADDR_W-1:0] instr_rs2;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_rd;
    logic              zero_flag;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  instr_ready, res_valid, res_data, res_rd, zero_flag
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output instr_ready, res_valid, res_data, res_rd, zero_flag
    );
endinterface

// File: rtl/alu16_regfile.sv
// 2**ADDR_W x DATA_W register file: two asynchronous read ports, one
// synchronous write port. Write-back has priority over an external write.
//   clk, rst_n          clock, async active-low reset (clears all entries)
//   rd1_*, rd2_*        asynchronous read ports
//   wb_we/addr/data     write-back port
//   ext_we/addr/data    external preload port
module alu16_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    assign rd1_data = mem_q[rd1_addr];
    assign rd2_data = mem_q[rd2_addr];

    always_comb begin
        mem_d = mem_q;
        if (wb_we) begin
            mem_d[wb_addr] = wb_data;
        end else if (ext_we) begin
            mem_d[ext_addr] = ext_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/alu16bit.sv
// 16-bit combinational ALU driven by alu16_exec_ctrl (instantiated by the
// parent). Shifts move by one bit; select codes 1100-1111 produce 0.
//   A, B      operands
//   ALU_Sel   operation select
//   ALU_Out   result
//   Zero      high when ALU_Out is all zeros
module alu16bit
    import alu16_pkg::*;
(
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [3:0]  ALU_Sel,
    output logic [15:0] ALU_Out,
    output logic        Zero
);
    always_comb begin
        ALU_Out = 16'h0000;
        case (ALU_Sel)
            OP_ADD:  ALU_Out = A + B;
            OP_SUB:  ALU_Out = A - B;
            OP_AND:  ALU_Out = A & B;
            OP_OR:   ALU_Out = A | B;
            OP_XOR:  ALU_Out = A ^ B;
            OP_NOR:  ALU_Out = ~(A | B);
            OP_NAND: ALU_Out = ~(A & B);
            OP_XNOR: ALU_Out = ~(A ^ B);
            OP_SHL:  ALU_Out = A << 1;
            OP_SHR:  ALU_Out = A >> 1;
            OP_ASHL: ALU_Out = A <<< 1;
            OP_ASHR: ALU_Out = $signed(A) >>> 1;
            default: ALU_Out = 16'h0000;
        endcase
    end

    assign Zero = (ALU_Out == 16'h0000);
endmodule

// File: rtl/alu16_exec_ctrl.sv
// Sequencing stage around the external 16-bit ALU: accepts one
// register-register instruction at a time, drives the ALU operands from the
// internal register file, captures the result and writes it back.
//   clk, rst_n              clock, async active-low reset
//   bus (slave)             instruction handshake and result publication
//   ext_we/addr/data        register-file preload, honoured only in IDLE
//   alu_a/alu_b/alu_sel     registered ALU inputs
//   alu_out/alu_zero        ALU result inputs
//   busy                    high whenever not IDLE
//
// state | meaning
// IDLE  | ready; accept registers operands, op and rd
// EXEC  | ALU inputs stable; result and Zero captured at the edge
// WB    | res_valid high; result written to rf[rd], zero_flag updated
module alu16_exec_ctrl
    import alu16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu16_exec_ctrl_if.slave     bus,
    input  logic                 ext_we,
    input  logic [ADDR_W-1:0]    ext_addr,
    input  logic [DATA_W-1:0]    ext_data,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [3:0]           alu_sel,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 alu_zero,
    output logic                 busy
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_rd_q, res_rd_d;
    logic              zero_int_q, zero_int_d;
    logic              zero_flag_q, zero_flag_d;
    logic              res_valid_q, res_valid_d;

    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    logic              wb_we;
    logic              ext_we_idle;

    assign wb_we       = (state_q == WB);
    assign ext_we_idle = ext_we && (state_q == IDLE);

    // Operand reads are taken from the pre-write array, so an ext write in the
    // accept cycle is not bypassed into the operands.
    alu16_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd1_addr (bus.instr_rs1),
        .rd1_data (rf_rd1),
        .rd2_addr (bus.instr_rs2),
        .rd2_data (rf_rd2),
        .wb_we    (wb_we),
        .wb_addr  (res_rd_q),
        .wb_data  (res_data_q),
        .ext_we   (ext_we_idle),
        .ext_addr (ext_addr),
        .ext_data (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rd_d        = rd_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        zero_int_d  = zero_int_q;
        zero_flag_d = zero_flag_q;
        res_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    alu_a_d   = rf_rd1;
                    alu_b_d   = rf_rd2;
                    alu_sel_d = bus.instr_op;
                    rd_d      = bus.instr_rd;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = alu_out;
                zero_int_d  = alu_zero;
                res_rd_d    = rd_q;
                res_valid_d = 1'b1;
                state_d     = WB;
            end
            WB: begin
                zero_flag_d = zero_int_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rd_q        <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            zero_int_q  <= 1'b0;
            zero_flag_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rd_q        <= rd_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            zero_int_q  <= zero_int_d;
            zero_flag_q <= zero_flag_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.zero_flag   = zero_flag_q;
    assign busy            = (state_q != IDLE);
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_sel         = alu_sel_q;
endmodule

// File: tb/tb_alu16_exec_ctrl.sv
module tb_alu16_exec_ctrl;
    import alu16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_we = 1'b0;
    logic [2:0]  ext_addr = '0;
    logic [15:0] ext_data = '0;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_zero, busy;

    always #5 clk = ~clk;

    alu16_exec_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    alu16_exec_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .ext_we   (ext_we),
        .ext_addr (ext_addr),
        .ext_data (ext_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .alu_zero (alu_zero),
        .busy     (busy)
    );

    alu16bit u_alu (
        .A       (alu_a),
        .B       (alu_b),
        .ALU_Sel (alu_sel),
        .ALU_Out (alu_out),
        .Zero    (alu_zero)
    );

    int n_vec = 0;
    int n_bad = 0;
    int rv_cnt = 0;
    logic [15:0] m_rf [8];

    always @(negedge clk) if (bus.res_valid) rv_cnt++;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ~(a & b);
            4'd7:  return ~(a ^ b);
            4'd8:  return 16'(a * 2);
            4'd9:  return a / 2;
            4'd10: return 16'(a * 2);
            4'd11: begin
                sa = int'($signed(a));
                return 16'(sa >>> 1);
            end
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] rf_act(input logic [2:0] idx);
        return dut.u_rf.mem_q[idx];
    endfunction

    // Called at posedge+1 while IDLE.
    task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
        ext_we = 1'b1; ext_addr = a; ext_data = d;
        @(posedge clk); #1;
        ext_we = 1'b0;
        m_rf[a] = d;
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input logic [2:0] rd,
                             input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic [15:0] exp_res, input logic exp_zero);
        int guard = 0;
        bus.instr_valid = 1'b1;
        bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
        while (!bus.instr_ready && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, " ready_wait"}, 32'(guard < 10), 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk({tag, " alu_a"}, 32'(alu_a), 32'(m_rf[rs1]));
        chk({tag, " alu_b"}, 32'(alu_b), 32'(m_rf[rs2]));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk({tag, " res_valid"}, 32'(bus.res_valid), 32'd1);
        chk({tag, " res_data"}, 32'(bus.res_data), 32'(exp_res));
        chk({tag, " res_rd"}, 32'(bus.res_rd), 32'(rd));
        @(posedge clk); #1;
        m_rf[rd] = exp_res;
        chk({tag, " res_valid_drop"}, 32'(bus.res_valid), 32'd0);
        chk({tag, " zero_flag"}, 32'(bus.zero_flag), 32'(exp_zero));
        chk({tag, " rf_rd"}, 32'(rf_act(rd)), 32'(exp_res));
        chk({tag, " ready"}, 32'(bus.instr_ready), 32'd1);
    endtask

    initial begin
        int rv0;
        logic [15:0] e;
        logic [3:0] rop;
        logic [2:0] rrd, rr1, rr2;

        bus.instr_valid = 1'b0;
        bus.instr_op = '0; bus.instr_rd = '0; bus.instr_rs1 = '0; bus.instr_rs2 = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;

        vecs[0] = '{4'b0000, 3'd3, 3'd1, 3'd2, 16'h0008, 1'b0};
        vecs[1] = '{4'b0001, 3'd4, 3'd1, 3'd1, 16'h0000, 1'b1};
        vecs[2] = '{4'b0001, 3'd5, 3'd2, 3'd1, 16'hFFFE, 1'b0};
        vecs[3] = '{4'b0100, 3'd6, 3'd3, 3'd1, 16'h000D, 1'b0};
        vecs[4] = '{4'b1100, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b1};
        vecs[5] = '{4'b1000, 3'd7, 3'd1, 3'd1, 16'h000A, 1'b0};
        vecs[6] = '{4'b1011, 3'd4, 3'd5, 3'd1, 16'hFFFF, 1'b0};
        vecs[7] = '{4'b0101, 3'd4, 3'd4, 3'd0, 16'h0000, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst res_data", 32'(bus.res_data), 32'd0);
        chk("rst alu_a", 32'(alu_a), 32'd0);
        chk("rst zero_flag", 32'(bus.zero_flag), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst ready", 32'(bus.instr_ready), 32'd1);

        // Table vectors
        ext_write(3'd1, 16'h0005);
        ext_write(3'd2, 16'h0003);
        for (int i = 0; i < 8; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs1,
                      vecs[i].rs2, vecs[i].exp_res, vecs[i].exp_zero);
        end

        // Dependent chain with instr_valid held
        rv0 = rv_cnt;
        bus.instr_valid = 1'b1;
        bus.instr_op = 4'b0000; bus.instr_rd = 3'd3; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
        @(posedge clk); #1;
        bus.instr_op = 4'b0100; bus.instr_rd = 3'd6; bus.instr_rs1 = 3'd3; bus.instr_rs2 = 3'd1;
        chk("chain ready_lo1", 32'(bus.instr_ready), 32'd0);
        @(posedge clk); #1;
        chk("chain ready_lo2", 32'(bus.instr_ready), 32'd0);
        @(posedge clk); #1;
        chk("chain ready_hi", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("chain ready_lo3", 32'(bus.instr_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("chain r3", 32'(rf_act(3'd3)), 32'h0008);
        chk("chain r6", 32'(rf_act(3'd6)), 32'h000D);
        chk("chain pulses", 32'(rv_cnt - rv0), 32'd2);
        m_rf[3] = 16'h0008; m_rf[6] = 16'h000D;

        // Ext write in accept cycle, then ext write during EXEC
        bus.instr_valid = 1'b1;
        bus.instr_op = 4'b0000; bus.instr_rd = 3'd7; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
        ext_we = 1'b1; ext_addr = 3'd1; ext_data = 16'h00FF;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("extacc alu_a", 32'(alu_a), 32'h0005);
        ext_addr = 3'd2; ext_data = 16'h1234;
        @(posedge clk); #1;
        ext_we = 1'b0;
        @(posedge clk); #1;
        chk("extacc r7", 32'(rf_act(3'd7)), 32'h0008);
        chk("extacc r1", 32'(rf_act(3'd1)), 32'h00FF);
        chk("extexec r2", 32'(rf_act(3'd2)), 32'h0003);
        m_rf[7] = 16'h0008; m_rf[1] = 16'h00FF;

        // Reset during EXEC
        rv0 = rv_cnt;
        bus.instr_valid = 1'b1;
        bus.instr_op = 4'b0000; bus.instr_rd = 3'd5; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst alu_a", 32'(alu_a), 32'd0);
        chk("midrst res_rd", 32'(bus.res_rd), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst r5", 32'(rf_act(3'd5)), 32'd0);
        chk("midrst pulses", 32'(rv_cnt - rv0), 32'd0);
        chk("midrst ready", 32'(bus.instr_ready), 32'd1);
        for (int i = 0; i < 8; i++) m_rf[i] = '0;

        // Randomized against the reference model
        for (int i = 0; i < 8; i++) ext_write(3'(i), 16'($urandom));
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            rrd = 3'($urandom_range(0, 7));
            rr1 = 3'($urandom_range(0, 7));
            rr2 = 3'($urandom_range(0, 7));
            e = ref_alu(rop, m_rf[rr1], m_rf[rr2]);
            run_instr($sformatf("rnd%0d", i), rop, rrd, rr1, rr2, e, e == 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
